// File: rtl/region_fill_pkg.sv
// Shared types and constants for the rectangular region fill engine.
package region_fill_pkg;

    localparam int DEF_X_W   = 8;
    localparam int DEF_Y_W   = 8;
    localparam int DEF_RGB_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_HSTRIPE = 2'd2;
    localparam logic [1:0] MODE_VSTRIPE = 2'd3;

endpackage

// File: rtl/region_fill_raster.sv
// Raster-order column/row counter for a w x h region; col innermost.
// Counters are one bit wider than the coordinates so a full-screen region fits.
module raster_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         advance,
    input  logic [X_W:0] w,
    input  logic [Y_W:0] h,
    output logic [X_W:0] col,
    output logic [Y_W:0] row,
    output logic         last
);

    localparam logic [X_W:0] COL_ONE = 1;
    localparam logic [Y_W:0] ROW_ONE = 1;

    logic col_end;

    assign col_end = (col == w - COL_ONE);
    assign last    = col_end && (row == h - ROW_ONE);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row + ROW_ONE;
            end else begin
                col <= col + COL_ONE;
            end
        end
    end

endmodule

// File: rtl/region_fill.sv
// Fills a rectangle one pixel/clk in one of four patterns on the shared VGA write bus.
// Bus is driven from the accepted start until the cycle after the done pulse, Z otherwise.
module region_fill
    import region_fill_pkg::*;
#(
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W,
    parameter int RGB_W = DEF_RGB_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [X_W-1:0]   x0,
    input  logic [Y_W-1:0]   y0,
    input  logic [X_W:0]     w,
    input  logic [Y_W:0]     h,
    input  logic [1:0]       mode,
    input  logic [RGB_W-1:0] color_a,
    input  logic [RGB_W-1:0] color_b,
    output wire  [X_W-1:0]   vga_x_out_bus,
    output wire  [Y_W-1:0]   vga_y_out_bus,
    output wire  [RGB_W-1:0] vga_RGB_out_bus,
    output wire              vga_draw_enable_bus,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_t             state;
    logic [X_W-1:0]     x0_r;
    logic [Y_W-1:0]     y0_r;
    logic [X_W:0]       w_r;
    logic [Y_W:0]       h_r;
    logic [1:0]         mode_r;
    logic [RGB_W-1:0]   color_a_r;
    logic [RGB_W-1:0]   color_b_r;

    logic [X_W:0]       col;
    logic [Y_W:0]       row;
    logic               last;
    logic               cnt_clear;
    logic               cnt_advance;

    logic               own;
    logic               strobe;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [RGB_W-1:0]   pix_rgb;
    logic               pick_b;

    assign cnt_clear   = (state == ST_LOAD);
    assign cnt_advance = (state == ST_DRAW);

    raster_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .w       (w_r),
        .h       (h_r),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // Pattern parity is taken from region-relative counters, not screen coordinates.
    always_comb begin
        pick_b = 1'b0;
        case (mode_r)
            MODE_CHECKER: pick_b = col[0] ^ row[0];
            MODE_HSTRIPE: pick_b = row[0];
            MODE_VSTRIPE: pick_b = col[0];
            default:      pick_b = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            own     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            done   <= 1'b0;
            strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    own  <= start;
                    busy <= start;
                    if (start) begin
                        aborted <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= (w_r == '0 || h_r == '0) ? ST_DONE : ST_DRAW;
                end
                ST_DRAW: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        strobe <= 1'b1;
                        if (last) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Latched request and pixel data need no reset: they are only visible while owning the bus.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            x0_r      <= x0;
            y0_r      <= y0;
            w_r       <= w;
            h_r       <= h;
            mode_r    <= mode;
            color_a_r <= color_a;
            color_b_r <= color_b;
        end
        if (state == ST_DRAW) begin
            pix_x   <= X_W'({1'b0, x0_r} + col);
            pix_y   <= Y_W'({1'b0, y0_r} + row);
            pix_rgb <= pick_b ? color_b_r : color_a_r;
        end
    end

    assign vga_x_out_bus       = own ? pix_x   : {X_W{1'bz}};
    assign vga_y_out_bus       = own ? pix_y   : {Y_W{1'bz}};
    assign vga_RGB_out_bus     = own ? pix_rgb : {RGB_W{1'bz}};
    assign vga_draw_enable_bus = own ? strobe  : 1'bz;

endmodule

// File: tb/tb_region_fill.sv
// Directed bench for region_fill: per-cycle compare against a raster model plus literal pixel tables.
module tb_region_fill;

    localparam int X_W   = 8;
    localparam int Y_W   = 8;
    localparam int RGB_W = 24;

    localparam int SOL_X [6] = '{10, 11, 12, 10, 11, 12};
    localparam int SOL_Y [6] = '{20, 20, 20, 21, 21, 21};
    localparam int WRP_X [8] = '{254, 255, 0, 1, 254, 255, 0, 1};
    localparam int WRP_Y [8] = '{255, 255, 255, 255, 0, 0, 0, 0};
    localparam logic [23:0] CHK_C [4] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [X_W-1:0]   x0 = '0;
    logic [Y_W-1:0]   y0 = '0;
    logic [X_W:0]     w = '0;
    logic [Y_W:0]     h = '0;
    logic [1:0]       mode = '0;
    logic [RGB_W-1:0] color_a = '0;
    logic [RGB_W-1:0] color_b = '0;
    wire  [X_W-1:0]   vx;
    wire  [Y_W-1:0]   vy;
    wire  [RGB_W-1:0] vrgb;
    wire              vde;
    wire              busy;
    wire              done;
    wire              aborted;

    region_fill #(.X_W(X_W), .Y_W(Y_W), .RGB_W(RGB_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .x0                  (x0),
        .y0                  (y0),
        .w                   (w),
        .h                   (h),
        .mode                (mode),
        .color_a             (color_a),
        .color_b             (color_b),
        .vga_x_out_bus       (vx),
        .vga_y_out_bus       (vy),
        .vga_RGB_out_bus     (vrgb),
        .vga_draw_enable_bus (vde),
        .busy                (busy),
        .done                (done),
        .aborted             (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model of the fill in flight: start sampled at edge k, n_pix strobes from t=2, done at t=done_t.
    bit          chk_en = 1'b0;
    bit          active = 1'b0;
    int          k = 0;
    int          n_pix = 0;
    int          done_t = 0;
    int          m_x0, m_y0, m_w, m_h, m_mode;
    logic [23:0] m_a, m_b;

    int          cap_x[$];
    int          cap_y[$];
    logic [23:0] cap_c[$];
    bit          seen [0:65535];

    int          cmp_t, ex, ey, key;
    logic [23:0] ec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void exp_pix(input int n, output int px, output int py, output logic [23:0] pc);
        int c;
        int r;
        c  = n % m_w;
        r  = n / m_w;
        px = (m_x0 + c) % 256;
        py = (m_y0 + r) % 256;
        case (m_mode)
            0:       pc = m_a;
            1:       pc = ((c + r) % 2 == 1) ? m_b : m_a;
            2:       pc = (r % 2 == 1) ? m_b : m_a;
            default: pc = (c % 2 == 1) ? m_b : m_a;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            cmp_t = cyc - k;
            if (active && cmp_t >= 0 && cmp_t <= done_t) begin
                chk("busy", {31'b0, busy}, 32'd1);
                chk("done", {31'b0, done}, {31'b0, cmp_t == done_t});
                chk("strobe", {31'b0, vde}, {31'b0, (cmp_t >= 2 && cmp_t < 2 + n_pix)});
                if (cmp_t >= 2 && cmp_t < 2 + n_pix) begin
                    exp_pix(cmp_t - 2, ex, ey, ec);
                    chk("pix_x", {24'b0, vx}, ex);
                    chk("pix_y", {24'b0, vy}, ey);
                    chk("pix_rgb", {8'b0, vrgb}, {8'b0, ec});
                    key = ey * 256 + ex;
                    chk("dup_pixel", {31'b0, seen[key]}, 32'd0);
                    seen[key] = 1'b1;
                    cap_x.push_back(int'(vx));
                    cap_y.push_back(int'(vy));
                    cap_c.push_back(vrgb);
                end
            end else begin
                chk("idle_busy", {31'b0, busy}, 32'd0);
                chk("idle_done", {31'b0, done}, 32'd0);
                chk("idle_z", {28'b0, vx === {X_W{1'bz}}, vy === {Y_W{1'bz}},
                               vrgb === {RGB_W{1'bz}}, vde === 1'bz}, 32'hF);
            end
        end
    end

    // kind: 0 plain, 1 abort on DRAW cycle 'at', 2 stray start at t='at', 3 reset at t='at'.
    task automatic launch(input int ax0, input int ay0, input int aw, input int ah, input int amode,
                          input logic [23:0] ca, input logic [23:0] cb, input int kind, input int at);
        m_x0 = ax0; m_y0 = ay0; m_w = aw; m_h = ah; m_mode = amode; m_a = ca; m_b = cb;
        n_pix  = aw * ah;
        done_t = n_pix + 2;
        if (kind == 1) begin
            n_pix  = at - 1;
            done_t = at + 2;
        end
        cap_x.delete();
        cap_y.delete();
        cap_c.delete();
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        x0 = ax0[X_W-1:0];
        y0 = ay0[Y_W-1:0];
        w = aw[X_W:0];
        h = ah[Y_W:0];
        mode = amode[1:0];
        color_a = ca;
        color_b = cb;
        start = 1'b1;
        k = cyc + 1;
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x0 = X_W'($urandom);
        y0 = Y_W'($urandom);
        w = (X_W+1)'($urandom);
        h = (Y_W+1)'($urandom);
        mode = 2'($urandom);
        color_a = RGB_W'($urandom);
        color_b = RGB_W'($urandom);
        while (cyc < k + done_t) begin
            abort = (kind == 1 && cyc == k + at);
            if (kind == 2 && cyc == k + at) begin
                start = 1'b1;
                x0 = 8'd99;
                w = 9'd1;
                h = 9'd1;
            end else begin
                start = 1'b0;
            end
            if (kind == 3 && cyc == k + at) begin
                reset = 1'b1;
                active = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_aborted", {31'b0, aborted}, 32'd0);
        chk("rst_z", {31'b0, vde === 1'bz && vx === {X_W{1'bz}}}, 32'd1);
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        launch(10, 20, 3, 2, 0, 24'hFF0000, 24'h00FF00, 0, 0);
        chk("solid_count", cap_x.size(), 32'd6);
        for (int i = 0; i < 6 && i < cap_x.size(); i++) begin
            chk("solid_x", cap_x[i], SOL_X[i]);
            chk("solid_y", cap_y[i], SOL_Y[i]);
            chk("solid_rgb", {8'b0, cap_c[i]}, 32'hFF0000);
        end
        chk("solid_not_aborted", {31'b0, aborted}, 32'd0);

        launch(0, 0, 2, 2, 1, 24'h000000, 24'hFFFFFF, 0, 0);
        chk("checker_count", cap_c.size(), 32'd4);
        for (int i = 0; i < 4 && i < cap_c.size(); i++)
            chk("checker_rgb", {8'b0, cap_c[i]}, {8'b0, CHK_C[i]});

        launch(254, 255, 4, 2, 0, 24'h123456, 24'h654321, 0, 0);
        chk("wrap_count", cap_x.size(), 32'd8);
        for (int i = 0; i < 8 && i < cap_x.size(); i++) begin
            chk("wrap_x", cap_x[i], WRP_X[i]);
            chk("wrap_y", cap_y[i], WRP_Y[i]);
        end
        repeat (2) @(negedge clk);

        launch(7, 9, 3, 3, 2, 24'hAAAAAA, 24'h555555, 2, 3);
        chk("hstripe_stray_start_count", cap_x.size(), 32'd9);
        launch(100, 50, 5, 2, 3, 24'h0000FF, 24'hFF00FF, 0, 0);
        chk("vstripe_count", cap_x.size(), 32'd10);

        launch(30, 40, 4, 4, 0, 24'h00FF00, 24'h000000, 1, 5);
        chk("abort_count", cap_x.size(), 32'd4);
        chk("abort_flag", {31'b0, aborted}, 32'd1);
        launch(1, 1, 1, 1, 0, 24'hABCDEF, 24'h000000, 0, 0);
        chk("abort_cleared", {31'b0, aborted}, 32'd0);
        chk("one_pixel_count", cap_x.size(), 32'd1);

        launch(5, 5, 0, 3, 0, 24'h111111, 24'h222222, 0, 0);
        chk("zero_w_count", cap_x.size(), 32'd0);
        repeat (2) @(negedge clk);

        launch(60, 70, 4, 4, 1, 24'h777777, 24'h888888, 3, 4);
        chk("reset_mid_count", cap_x.size(), 32'd3);
        repeat (3) @(negedge clk);
        chk("reset_mid_aborted", {31'b0, aborted}, 32'd0);

        launch(0, 0, 256, 256, 0, 24'h0F0F0F, 24'hF0F0F0, 0, 0);
        chk("full_count", cap_x.size(), 32'd65536);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
